// File: rtl/int_pos_gen.sv
// int_pos_gen: raster-position interrupt request generator.
// Tracks beam position from video sync strobes and emits single-cycle frame
// and line interrupt pulses at software-programmed positions. Position
// registers are double-buffered: CPU writes land in pending registers and are
// promoted to the active set on frame_start.
// Optional feature macro: INTGEN_LINE_SKIP_EN (line interrupt divider, LSKIP
// register at address 3). With the macro undefined every line is selected and
// address 3 writes are ignored.
module int_pos_gen #(
  parameter int HCNT_W = 8,
  parameter int VCNT_W = 9
) (
  input  logic              clk,
  input  logic              res,
  input  logic              frame_start,
  input  logic              line_start,
  input  logic              hstb,
  input  logic              wr_stb,
  input  logic [1:0]        wr_addr,
  input  logic [7:0]        wr_data,
  output logic              int_start_frm,
  output logic              int_start_lin,
  output logic [HCNT_W-1:0] hcnt,
  output logic [VCNT_W-1:0] vcnt
);

  localparam int HPOS_W = 8;
  localparam int VPOS_W = 9;

  localparam logic [1:0] ADDR_HPOS  = 2'd0;
  localparam logic [1:0] ADDR_VPOSL = 2'd1;
  localparam logic [1:0] ADDR_VPOSH = 2'd2;
`ifdef INTGEN_LINE_SKIP_EN
  localparam logic [1:0] ADDR_LSKIP = 2'd3;
  localparam int         LSKIP_W    = 8;
`endif

  // Saturating increment helpers: counters stick at all-ones so that an
  // all-ones position stays reachable on overlong lines/frames.
  function automatic logic [HCNT_W-1:0] sat_inc_h(input logic [HCNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [VCNT_W-1:0] sat_inc_v(input logic [VCNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Pending (CPU-visible) and active (comparator-visible) position registers
  logic [HPOS_W-1:0] pend_hpos;
  logic [VPOS_W-1:0] pend_vpos;
  logic [HPOS_W-1:0] act_hpos;
  logic [VPOS_W-1:0] act_vpos;

`ifdef INTGEN_LINE_SKIP_EN
  logic [LSKIP_W-1:0] pend_lskip;
  logic [LSKIP_W-1:0] act_lskip;
  logic [LSKIP_W-1:0] line_div;
`endif

  // Arm flags and stage-0 match terms (combinational on registered counters)
  logic arm_frm;
  logic arm_lin;
  logic h_hit_p0;
  logic v_hit_p0;
  logic line_sel_p0;
  logic frm_fire_p0;
  logic lin_fire_p0;

  // CPU writes update pending registers immediately
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      pend_hpos <= '0;
      pend_vpos <= '0;
    end else if (wr_stb) begin
      case (wr_addr)
        ADDR_HPOS:  pend_hpos      <= wr_data;
        ADDR_VPOSL: pend_vpos[7:0] <= wr_data;
        ADDR_VPOSH: pend_vpos[8]   <= wr_data[0];
        default: ;
      endcase
    end
  end

`ifdef INTGEN_LINE_SKIP_EN
  // LSKIP pending register, written through address 3
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      pend_lskip <= '0;
    end else if (wr_stb && (wr_addr == ADDR_LSKIP)) begin
      pend_lskip <= wr_data;
    end
  end
`endif

  // Promote pending to active at the frame boundary; a same-cycle write is
  // not seen here because pending only updates at this same edge
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      act_hpos <= '0;
      act_vpos <= '0;
    end else if (frame_start) begin
      act_hpos <= pend_hpos;
      act_vpos <= pend_vpos;
    end
  end

`ifdef INTGEN_LINE_SKIP_EN
  // Active LSKIP load at the frame boundary
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      act_lskip <= '0;
    end else if (frame_start) begin
      act_lskip <= pend_lskip;
    end
  end

  // Line divider: 0 on line 0, counts lines and wraps after act_lskip
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      line_div <= '0;
    end else if (frame_start) begin
      line_div <= '0;
    end else if (line_start) begin
      line_div <= (line_div == act_lskip) ? '0 : line_div + 1'b1;
    end
  end
`endif

  // Horizontal position: cleared per line, line_start beats hstb
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      hcnt <= '0;
    end else if (line_start) begin
      hcnt <= '0;
    end else if (hstb) begin
      hcnt <= sat_inc_h(hcnt);
    end
  end

  // Vertical position: cleared per frame, counts line starts
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      vcnt <= '0;
    end else if (frame_start) begin
      vcnt <= '0;
    end else if (line_start) begin
      vcnt <= sat_inc_v(vcnt);
    end
  end

  // Stage 0: compare registered counters against the active positions
  always_comb begin
    h_hit_p0    = (32'(hcnt) == 32'(act_hpos));
    v_hit_p0    = (32'(vcnt) == 32'(act_vpos));
`ifdef INTGEN_LINE_SKIP_EN
    line_sel_p0 = (line_div == '0);
`else
    line_sel_p0 = 1'b1;
`endif
    frm_fire_p0 = arm_frm && v_hit_p0 && h_hit_p0;
    lin_fire_p0 = arm_lin && h_hit_p0 && line_sel_p0;
  end

  // Frame arm flag: set per frame, dropped once the pulse has been issued
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      arm_frm <= 1'b0;
    end else if (frame_start) begin
      arm_frm <= 1'b1;
    end else if (frm_fire_p0) begin
      arm_frm <= 1'b0;
    end
  end

  // Line arm flag: set per line, dropped once the pulse has been issued
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      arm_lin <= 1'b0;
    end else if (line_start) begin
      arm_lin <= 1'b1;
    end else if (lin_fire_p0) begin
      arm_lin <= 1'b0;
    end
  end

  // Stage 1: registered interrupt pulses, one cycle wide since the arm
  // flag drops on the same edge
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      int_start_frm <= 1'b0;
      int_start_lin <= 1'b0;
    end else begin
      int_start_frm <= frm_fire_p0;
      int_start_lin <= lin_fire_p0;
    end
  end

endmodule

// File: tb/tb_int_pos_gen.sv
// tb_int_pos_gen: directed bench for int_pos_gen with a pulse monitor that
// records where and when each interrupt fires, per frame.
module tb_int_pos_gen;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       frame_start = 1'b0;
  logic       line_start = 1'b0;
  logic       hstb = 1'b0;
  logic       wr_stb = 1'b0;
  logic [1:0] wr_addr = 2'd0;
  logic [7:0] wr_data = 8'd0;
  logic       int_start_frm;
  logic       int_start_lin;
  logic [7:0] hcnt;
  logic [8:0] vcnt;

  int n_chk = 0;
  int n_fail = 0;

  int_pos_gen #(.HCNT_W(8), .VCNT_W(9)) dut (
    .clk(clk), .res(res), .frame_start(frame_start), .line_start(line_start),
    .hstb(hstb), .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
    .int_start_frm(int_start_frm), .int_start_lin(int_start_lin),
    .hcnt(hcnt), .vcnt(vcnt)
  );

  always #5 clk = ~clk;

  // Monitor state (written only by the monitor process)
  int          cyc = 0;
  int          cyc_fs = 0;
  int          frm_tot = 0;
  int          lin_tot = 0;
  int          dbl = 0;
  int          frm_f = 0;
  int          lin_f = 0;
  int          both_f = 0;
  int          frm_dly = 0;
  int          frm_h = 0;
  int          frm_v = 0;
  int          lin_hmin = 255;
  int          lin_hmax = 0;
  logic [31:0] lin_mask_f = '0;
  logic [7:0]  prev_h = '0;
  logic [8:0]  prev_v = '0;
  logic        prev_frm = 1'b0;
  logic        prev_lin = 1'b0;

  // Record pulses mid-cycle; positions are the counter values of the
  // previous cycle, which is the cycle in which the match happened
  always @(negedge clk) begin
    cyc++;
    if (int_start_frm) begin
      frm_tot++;
      frm_f++;
      frm_h = int'(prev_h);
      frm_v = int'(prev_v);
      frm_dly = cyc - cyc_fs;
      if (prev_frm) dbl++;
    end
    if (int_start_lin) begin
      lin_tot++;
      lin_f++;
      if (int'(prev_h) < lin_hmin) lin_hmin = int'(prev_h);
      if (int'(prev_h) > lin_hmax) lin_hmax = int'(prev_h);
      if (prev_v < 9'd32) lin_mask_f = lin_mask_f | (32'd1 << prev_v);
      if (prev_lin) dbl++;
    end
    if (int_start_frm && int_start_lin) both_f++;
    prev_frm = int_start_frm;
    prev_lin = int_start_lin;
    prev_h = hcnt;
    prev_v = vcnt;
    if (frame_start) begin
      cyc_fs = cyc;
      frm_f = 0;
      lin_f = 0;
      both_f = 0;
      lin_hmin = 255;
      lin_hmax = 0;
      lin_mask_f = '0;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    wr_stb = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_stb = 1'b0;
  endtask

  // One frame: each line is a line_start cycle followed by nh hstb cycles
  task automatic run_frame(input int nlines, input int nh);
    for (int i = 0; i < nlines; i++) begin
      @(posedge clk); #1;
      frame_start = (i == 0); line_start = 1'b1; hstb = 1'b0;
      for (int k = 0; k < nh; k++) begin
        @(posedge clk); #1;
        frame_start = 1'b0; line_start = 1'b0; hstb = 1'b1;
      end
    end
    @(posedge clk); #1;
    frame_start = 1'b0; line_start = 1'b0; hstb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  int  snap_lin = 0;
  int  snap_frm = 0;
  logic got = 1'b0;

  initial begin
    // Reset state
    #2;
    check_val("rst_hcnt", 32'(hcnt), 32'h0);
    check_val("rst_vcnt", 32'(vcnt), 32'h0);
    check_val("rst_frm", 32'(int_start_frm), 32'h0);
    check_val("rst_lin", 32'(int_start_lin), 32'h0);
    repeat (2) @(posedge clk);
    #1 res = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Default position (0,0)
    run_frame(4, 4);
    check_val("p00_frm_cnt", 32'(frm_f), 32'd1);
    check_val("p00_frm_dly", 32'(frm_dly), 32'd2);
    check_val("p00_both", 32'(both_f), 32'd1);
    check_val("p00_lin_cnt", 32'(lin_f), 32'd4);
    check_val("p00_lin_h", 32'(lin_hmax), 32'd0);

    // Mid-frame write takes effect only in the next frame
    fork
      run_frame(270, 34);
      begin
        repeat (10) @(posedge clk);
        wr_reg(2'd0, 8'h20);
        wr_reg(2'd2, 8'h01);
        wr_reg(2'd1, 8'h05);
      end
    join
    check_val("mid_cur_cnt", 32'(frm_f), 32'd1);
    check_val("mid_cur_pos", 32'((frm_v << 8) | frm_h), 32'h0);
    check_val("mid_cur_lin", 32'(lin_f), 32'd270);
    run_frame(270, 34);
    check_val("mid_nxt_cnt", 32'(frm_f), 32'd1);
    check_val("mid_nxt_h", 32'(frm_h), 32'h20);
    check_val("mid_nxt_v", 32'(frm_v), 32'h105);
    check_val("mid_nxt_lin", 32'(lin_f), 32'd270);
    check_val("mid_nxt_linh", 32'(lin_hmin), 32'h20);

    // Unreachable VPOS on a 320-line frame
    wr_reg(2'd0, 8'h02);
    wr_reg(2'd2, 8'h01);
    wr_reg(2'd1, 8'hF0);
    for (int f = 0; f < 3; f++) begin
      run_frame(320, 4);
      check_val("unr_frm_cnt", 32'(frm_f), 32'd0);
      check_val("unr_lin_cnt", 32'(lin_f), 32'd320);
      check_val("unr_lin_h", 32'((lin_hmax << 8) | lin_hmin), 32'h0202);
    end

    // Write coincident with frame_start
    wr_reg(2'd2, 8'h00);
    wr_reg(2'd1, 8'h03);
    wr_reg(2'd0, 8'h01);
    run_frame(8, 4);
    check_val("co_pre_pos", 32'((frm_v << 8) | frm_h), 32'h0301);
    fork
      run_frame(8, 4);
      wr_reg(2'd1, 8'h05);
    join
    check_val("co_old_cnt", 32'(frm_f), 32'd1);
    check_val("co_old_pos", 32'((frm_v << 8) | frm_h), 32'h0301);
    run_frame(8, 4);
    check_val("co_new_cnt", 32'(frm_f), 32'd1);
    check_val("co_new_pos", 32'((frm_v << 8) | frm_h), 32'h0501);

    // hcnt saturation with HPOS = 0xFF
    wr_reg(2'd0, 8'hFF);
    run_frame(2, 300);
    check_val("sat_lin_cnt", 32'(lin_f), 32'd2);
    check_val("sat_lin_h", 32'(lin_hmin), 32'hFF);
    check_val("sat_frm_cnt", 32'(frm_f), 32'd0);
    check_val("sat_hcnt", 32'(hcnt), 32'hFF);
    check_val("sat_vcnt", 32'(vcnt), 32'h1);

    // Line skip of 2 (every line when the divider is not built)
    wr_reg(2'd0, 8'h00);
    wr_reg(2'd3, 8'h02);
    run_frame(7, 2);
`ifdef INTGEN_LINE_SKIP_EN
    check_val("skip_mask", lin_mask_f, 32'h49);
    check_val("skip_cnt", 32'(lin_f), 32'd3);
`else
    check_val("skip_mask", lin_mask_f, 32'h7F);
    check_val("skip_cnt", 32'(lin_f), 32'd7);
`endif
    check_val("skip_frm_pos", 32'((frm_v << 8) | frm_h), 32'h0500);
    wr_reg(2'd3, 8'h00);

    // Reset mid-line while the pulses are high and the line is still live
    wr_reg(2'd0, 8'h10);
    wr_reg(2'd1, 8'h00);
    fork
      run_frame(2, 40);
      begin
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
          @(negedge clk);
          if (int_start_frm) got = 1'b1;
        end
        check_val("rm_seen_frm", 32'(got), 32'h1);
        if (got) begin
          #1;
          check_val("rm_lin_hi", 32'(int_start_lin), 32'h1);
          res = 1'b1;
          #1;
          check_val("rm_frm_clr", 32'(int_start_frm), 32'h0);
          check_val("rm_lin_clr", 32'(int_start_lin), 32'h0);
          check_val("rm_hcnt_clr", 32'(hcnt), 32'h0);
          @(posedge clk);
          @(posedge clk);
          #1 res = 1'b0;
          snap_lin = lin_tot;
          snap_frm = frm_tot;
          got = 1'b0;
          for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (line_start) got = 1'b1;
          end
          check_val("rm_seen_ls", 32'(got), 32'h1);
          check_val("rm_no_lin", 32'(lin_tot), 32'(snap_lin));
        end
      end
    join
    check_val("rm_lin_resume", 32'(lin_tot), 32'(snap_lin + 1));
    check_val("rm_no_frm", 32'(frm_tot), 32'(snap_frm));

    check_val("pulse_width", 32'(dbl), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
